mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the processor's data-memory bus, downstream of the load/store path. The core's store writes bytes into a small TX FIFO. A serializer drains the FIFO onto TxLine as 8N1 frames. The core's loads read status and configuration combinationally, so a load completes in the same cycle, as the single-cycle datapath requires. Hit lets the top level steer ReadData into the MemtoReg path instead of the data-memory output.

Parameters:
BASE_ADDRESS  32'h1001_0400  base of the 16-byte register window; Address[3:0] is the offset
FIFO_DEPTH  4  TX FIFO entries; must be a power of two, 2..16
DEFAULT_DIVISOR  16'd434  clocks per bit after reset (50 MHz / 115200)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
Address  input  32  byte address from ALU result
WriteData  input  32  store data (register file ReadData2)
MemWrite  input  1  store strobe, one cycle per store
MemRead  input  1  load strobe
ReadData  output  32  register read data, combinational
Hit  output  1  Address[31:4]==BASE_ADDRESS[31:4], combinational
TxLine  output  1  serial output, registered, idles high
TxBusy  output  1  serializer not in IDLE, registered

Behaviour:
- Reset: one clk edge with reset=1 produces the following reset state.
  - TxLine=1, TxBusy=0.
  - FIFO empty, count=0.
  - Overflow flag=0.
  - Divisor=DEFAULT_DIVISOR.
  - FSM=IDLE.
  - Reset mid-frame aborts the frame at once; queued bytes are discarded.
- Register map, selected by Address[3:2] when Hit=1. Address[1:0] is ignored.
  - 0 TXDATA: a write pushes WriteData[7:0]. Reads return 0.
  - 1 STATUS: read only. Bits: 0 TxBusy, 1 full, 2 empty, 3 overflow (sticky), [8:4] count. Other bits are 0. Any write to STATUS clears overflow.
  - 2 DIVISOR: a write sets divisor=WriteData[15:0]. Reads return {16'b0, divisor}.
  - 3 reserved: reads return 0; writes are ignored.
- ReadData = selected register when Hit && MemRead; otherwise 32'b0.
- Writes take effect only when Hit && MemWrite, at the rising edge.
- A divisor value of 0 behaves as 1. The effective divisor is latched when each frame starts. A write mid-frame affects only later frames.
- FIFO push:
  - A TXDATA write while full is dropped and sets overflow.
  - A pop and a push in the same cycle are both accepted, even when full; count is unchanged.
  - FIFO order is strict first-in, first-out. Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: TxLine=1. If the FIFO is non-empty at an edge: pop into an 8-bit shift register, load bit counter=0 and baud counter=divisor-1, go to START. A byte pushed at edge E0 is popped at E1, and TxLine goes low after E1.
  - START: TxLine=0 for exactly divisor cycles, then go to DATA.
  - DATA: TxLine=shift[0], LSB first. Each bit lasts divisor cycles. Shift right after each bit. After bit 7, go to STOP.
  - STOP: TxLine=1 for divisor cycles. At its last cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
  - Baud counter: decrements each cycle; the bit ends when it is 0 and it then reloads divisor-1.
  - A frame lasts exactly 10*divisor cycles.
- TxBusy=1 in START, DATA and STOP. TxBusy is registered, so it changes together with the state.
- MemRead and MemWrite both high in one cycle: both are serviced. The read returns the pre-edge value.
- Without Hit, the block ignores the bus entirely.

Test Plan:
- Reset, then read STATUS at 0x1001_0404 -> ReadData=0x0000_0004 (empty). TxLine=1. DIVISOR reads 434.
- Write DIVISOR=4, then write TXDATA=0xA5 -> TxLine low for 4 cycles starting one edge after the write. Data bits follow LSB first, 1,0,1,0,0,1,0,1, each 4 cycles. Stop bit high for 4 cycles. TxBusy is high for exactly 40 cycles.
- DIVISOR=2: write 0x11, 0x22, 0x33 back-to-back -> three frames of 20 cycles each with no idle gap. STATUS count reads 2, 1, 0 as each byte is popped.
- Hold the FSM busy with DIVISOR=100, write 6 bytes -> bytes 1-5 accepted (one popped, four queued) and byte 6 dropped. STATUS = full|overflow|busy with count=4. A STATUS write clears bit 3 only.
- Write DIVISOR=3 mid-frame at divisor 4 -> the current frame stays at 40 cycles and the next frame is 30 cycles. Write DIVISOR=0 -> frame of 10 cycles.
- Assert reset in the middle of a DATA bit with 2 bytes queued -> after that edge TxLine=1, TxBusy=0, STATUS=0x4, no further frames. An access at 0x1001_0500 gives Hit=0 and ReadData=0 with no state change.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register reads are combinational so a load completes in the same cycle.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h1001_0400,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxLine,
    output logic        TxBusy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateType;

    stateType        state;
    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr, rdPtr;
    logic [4:0]      count;
    logic            overflow;
    logic [15:0]     divisor, effDiv, curDiv, baudCnt;
    logic [7:0]      shifter;
    logic [2:0]      bitCnt;
    logic [1:0]      sel;
    logic [31:0]     status;
    logic            wrEn, push, pop, accept, full, empty, bitEnd;
    logic            unusedBits;

    assign unusedBits = ^{Address[1:0], WriteData[31:16]};

    always_comb begin
        Hit      = Address[31:4] == BASE_ADDRESS[31:4];
        sel      = Address[3:2];
        wrEn     = Hit && MemWrite;
        push     = wrEn && sel == 2'd0;
        full     = count == 5'(FIFO_DEPTH);
        empty    = count == 5'd0;
        bitEnd   = baudCnt == 16'd0;
        pop      = !empty && (state == IDLE || (state == STOP && bitEnd));
        accept   = push && (!full || pop);
        effDiv   = divisor == 16'd0 ? 16'd1 : divisor;
        status   = {23'b0, count, overflow, empty, full, TxBusy};
        ReadData = !(Hit && MemRead) ? 32'b0 :
                   sel == 2'd1 ? status :
                   sel == 2'd2 ? {16'b0, divisor} : 32'b0;
    end

    always_ff @(posedge clk)
        if (accept) fifoMem[wrPtr] <= WriteData[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
            divisor  <= DEFAULT_DIVISOR;
        end else begin
            if (accept) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + 5'(accept) - 5'(pop);
            if (push && !accept) overflow <= 1'b1;
            else if (wrEn && sel == 2'd1) overflow <= 1'b0;
            if (wrEn && sel == 2'd2) divisor <= WriteData[15:0];
        end
    end

    // A pop always starts a frame, whether from IDLE or from the last STOP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            TxLine  <= 1'b1;
            TxBusy  <= 1'b0;
            shifter <= 8'd0;
            bitCnt  <= 3'd0;
            baudCnt <= 16'd0;
            curDiv  <= 16'd1;
        end else if (pop) begin
            state   <= START;
            TxLine  <= 1'b0;
            TxBusy  <= 1'b1;
            shifter <= fifoMem[rdPtr];
            bitCnt  <= 3'd0;
            curDiv  <= effDiv;
            baudCnt <= effDiv - 16'd1;
        end else if (state != IDLE) begin
            if (!bitEnd) begin
                baudCnt <= baudCnt - 16'd1;
            end else begin
                baudCnt <= curDiv - 16'd1;
                if (state == START) begin
                    state  <= DATA;
                    TxLine <= shifter[0];
                end else if (state == DATA && bitCnt != 3'd7) begin
                    bitCnt  <= bitCnt + 3'd1;
                    shifter <= shifter >> 1;
                    TxLine  <= shifter[1];
                end else if (state == DATA) begin
                    state  <= STOP;
                    TxLine <= 1'b1;
                end else begin
                    state  <= IDLE;
                    TxBusy <= 1'b0;
                end
            end
        end
    end
endmodule
